seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle 32-bit integer divider for the pipelined MIPS core's HI/LO unit; the inverse operation paired with the Booth multiplier. It accepts one DIV/DIVU request via a start pulse and computes quotient (LO) and remainder (HI) by radix-2 restoring division on operand magnitudes. It applies a sign fix-up stage, then signals completion with a one-cycle done pulse. The stall logic holds dependent MFHI/MFLO instructions while busy is high.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- signed_op  input  1  1 = DIV (two's complement), 0 = DIVU; captured at start.
- dividend  input  WIDTH  numerator; captured at start.
- divisor  input  WIDTH  denominator; captured at start.
- quotient  output  WIDTH  registered result (LO).
- remainder  output  WIDTH  registered result (HI).
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse when results update.
- div_zero  output  1  high with done when divisor was 0; held until the next done.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with start=1 and divisor != 0:
  - Latch the sign flags: sign_q = signed_op & (dividend[31] ^ divisor[31]) and sign_r = signed_op & dividend[31].
  - Latch the magnitudes |dividend| and |divisor|. These equal the raw values when signed_op=0.
  - Clear the partial remainder and set the iteration count to 0. Go to CALC.
- IDLE with start=1 and divisor == 0: go to FIX with the dz flag set. No iterations run.
- CALC runs one iteration per cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Compute trial = partial remainder - divisor magnitude, using a WIDTH+1-bit subtract.
  - If trial is non-negative, the partial remainder takes trial and the quotient LSB is 1. Otherwise the quotient LSB is 0.
  - After WIDTH iterations, go to FIX.
- FIX:
  - quotient = sign_q ? -q_mag : q_mag.
  - remainder = sign_r ? -r_mag : r_mag.
  - Set done=1 and div_zero=0, then go to IDLE.
- FIX with dz set: quotient = all ones, remainder = dividend as captured, div_zero=1, done=1.
- Overflow (signed 0x80000000 / 0xFFFFFFFF): gives quotient 0x80000000 and remainder 0. This falls out of the magnitude path (2^31 negated truncates to 0x80000000). No special case is needed.
- Rounding: the quotient truncates toward zero. The remainder sign follows the dividend, or the remainder is zero.
- start while busy is ignored. It is not queued.
- Operand inputs are don't-care after the start cycle.
- quotient, remainder and div_zero hold their values until the next FIX.

## Timing
- Reset values: quotient=0, remainder=0, busy=0, done=0, div_zero=0, state=IDLE.
- Reset takes effect at the next rising edge from any state. It aborts an operation in progress: no done is produced and the outputs are cleared.
- Normal latency:
  - Start is sampled at edge 0.
  - CALC covers edges 1..32.
  - FIX registers results at edge 33.
  - done is high from edge 33 to edge 34, so latency is 33 cycles.
  - busy is high from edge 0 to edge 33.
- Divide-by-zero latency: start at edge 0, FIX at edge 1. done and div_zero are high from edge 1 to edge 2, and busy is high for 1 cycle.
- In the done cycle the state is already IDLE and busy=0. A start in that cycle is accepted at edge 34, which gives back-to-back throughput of one division per 34 cycles.
- done is never asserted for two consecutive cycles.

## Test plan
- Signed -7 / 2 (0xFFFFFFF9 / 0x2, signed_op=1):
  - quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, div_zero=0.
  - done exactly 33 cycles after the start edge.
- Unsigned 0xFFFFFFFF / 0x10 (signed_op=0): quotient=0x0FFFFFFF, remainder=0xF.
- Signed 100 / -7: quotient=0xFFFFFFF2 (-14), remainder=0x2.
- Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Divisor zero, dividend 30:
  - Expect quotient=0xFFFFFFFF, remainder=30, div_zero=1.
  - done 1 cycle after start; busy high for 1 cycle.
- Start 8/3 unsigned, then pulse start with 9/3 at cycle 5, then assert rst at cycle 10:
  - The second start is ignored.
  - After the reset edge: busy=0, quotient=0, remainder=0, and no done.
  - A fresh 8/3 started afterwards gives quotient=2, remainder=2.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider producing quotient (LO) and remainder (HI)
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] prem_q, dvd_q, dsr_q, raw_q, quo_q, rem_q;
   logic [CW-1:0]    cnt_q;
   logic             sgn_q_q, sgn_r_q, dz_q, done_q, dz_out_q;
   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] prem_d, dvd_d, a_mag, b_mag;
   // one restoring step: the dividend register doubles as the quotient shift register
   always_comb begin
      shifted = {prem_q, dvd_q[WIDTH-1]};
      trial   = shifted - {1'b0, dsr_q};
      prem_d  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      dvd_d   = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
      a_mag   = (signed_op & dividend[WIDTH-1]) ? -dividend : dividend;
      b_mag   = (signed_op & divisor[WIDTH-1]) ? -divisor : divisor;
   end
   // control FSM with registered results; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         quo_q    <= '0;
         rem_q    <= '0;
         done_q   <= 1'b0;
         dz_out_q <= 1'b0;
         dz_q     <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               raw_q   <= dividend;
               sgn_q_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               sgn_r_q <= signed_op & dividend[WIDTH-1];
               dvd_q   <= a_mag;
               dsr_q   <= b_mag;
               prem_q  <= '0;
               cnt_q   <= '0;
               dz_q    <= divisor == '0;
               state_q <= divisor == '0 ? FIX : CALC;
            end
            CALC: begin
               prem_q  <= prem_d;
               dvd_q   <= dvd_d;
               cnt_q   <= cnt_q + 1'b1;
               state_q <= cnt_q == CW'(WIDTH - 1) ? FIX : CALC;
            end
            FIX: begin
               quo_q    <= dz_q ? '1 : (sgn_q_q ? -dvd_q : dvd_q);
               rem_q    <= dz_q ? raw_q : (sgn_r_q ? -prem_q : prem_q);
               dz_out_q <= dz_q;
               done_q   <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign div_zero  = dz_out_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench comparing the divider against integer-arithmetic expectations
module tb_seq_divider;
   logic        clk = 1'b0;
   logic        rst, start, signed_op;
   logic [31:0] dividend, divisor, quotient, remainder;
   logic        busy, done, div_zero;
   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          t;
      int          lat;
   } exp_t;
   exp_t exp_q[$];
   int   checks = 0, errors = 0, cyc = 0;
   seq_divider dut (
      .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
      .dividend(dividend), .divisor(divisor), .quotient(quotient),
      .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask
   function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
      exp_t   m;
      longint x, y, q, r;
      m.t   = 0;
      m.lat = (b == 0) ? 1 : 33;
      m.dz  = (b == 0);
      if (b == 0) begin
         m.q = 32'hFFFF_FFFF;
         m.r = a;
         return m;
      end
      x   = s ? longint'($signed(a)) : longint'(a);
      y   = s ? longint'($signed(b)) : longint'(b);
      q   = x / y;
      r   = x % y;
      m.q = q[31:0];
      m.r = r[31:0];
      return m;
   endfunction
   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
      exp_t e;
      @(posedge clk);
      #1 start = 1'b1; signed_op = s; dividend = a; divisor = b;
      @(posedge clk);
      #1 start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
      if (expect_it) begin
         e   = model(s, a, b);
         e.t = cyc;
         exp_q.push_back(e);
         chk("busy_after_start", 32'(busy), 32'd1);
      end
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) begin
         chk("timeout_pending", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask
   // monitor: pops the scoreboard whenever the divider reports completion
   initial begin
      exp_t e;
      bit   prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            if (prev_done) chk("done_twice", 32'd1, 32'd0);
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("div_zero", 32'(div_zero), 32'(e.dz));
               chk("latency", 32'(cyc - e.t), 32'(e.lat));
               chk("busy_at_done", 32'(busy), 32'd0);
            end
         end
         prev_done = !rst && done;
      end
   end
   initial begin
      int n;
      logic [31:0] a, b;
      rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_div_zero", 32'(div_zero), 32'd0);
      issue(1'b1, 32'hFFFF_FFF9, 32'h2, 1'b1);         wait_idle();
      issue(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b1);        wait_idle();
      issue(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1);       wait_idle();
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
      issue(1'b0, 32'd30, 32'd0, 1'b1);                wait_idle();
      issue(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b1);         wait_idle();
      issue(1'b0, 32'd5, 32'd7, 1'b1);                 wait_idle();
      issue(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1);         wait_idle();
      issue(1'b1, 32'h8000_0000, 32'h1, 1'b1);         wait_idle();
      // a start while busy is dropped and must not produce a second result
      issue(1'b0, 32'd8, 32'd3, 1'b1);
      repeat (3) @(posedge clk);
      issue(1'b0, 32'd9, 32'd3, 1'b0);
      wait_idle();
      repeat (40) @(posedge clk);
      // reset in mid-calculation aborts the operation
      issue(1'b0, 32'd8, 32'd3, 1'b1);
      repeat (3) @(posedge clk);
      issue(1'b0, 32'd9, 32'd3, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_quotient", quotient, 32'd0);
      chk("abort_remainder", remainder, 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("abort_no_done", 32'(n), 32'd0);
      issue(1'b0, 32'd8, 32'd3, 1'b1); wait_idle();
      // randomized operations, biased toward small and zero divisors
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'($urandom_range(0, 15));
            1: b = -32'($urandom_range(1, 15));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         issue(1'($urandom), a, b, 1'b1);
         wait_idle();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
